mtpsa_digest_extract: RTL

MTPSA_DIGEST_EXTRACT -- requirements
Module: mtpsa_digest_extract

---
 rtl/mtpsa_pkg.sv | 28 ++
 rtl/mtpsa_digest_fifo.sv | 62 ++++++
 rtl/mtpsa_digest_extract.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mtpsa_pkg.sv
// mtpsa_pkg: shared tuser field map, digest width, FSM state encoding
// and a saturating counter helper for the digest-extract stage.
package mtpsa_pkg;

    // Bit positions inside the 304-bit switch-output tuser
    localparam int TU_PKT_LEN_LSB  = 0;
    localparam int TU_PKT_LEN_W    = 16;
    localparam int TU_SRC_PORT_LSB = 16;
    localparam int TU_DST_PORT_LSB = 24;
    localparam int TU_PORT_W       = 8;
    localparam int TU_DROP_BIT     = 32;
    localparam int TU_SEND_DIG_BIT = 40;
    localparam int TU_DIGEST_LSB   = 48;
    localparam int TU_META_W       = 48;

    localparam int DIGEST_W = 256;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/mtpsa_digest_fifo.sv
// mtpsa_digest_fifo: synchronous FIFO with registered full/empty flags.
// Ports: clk/rst, i_push/i_data, i_pop, o_data (head), o_full, o_empty, o_count.
module mtpsa_digest_fifo
    import mtpsa_pkg::*;
#(
    parameter int W     = DIGEST_W,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [W-1:0]      i_data,
    input  logic              i_pop,
    output logic [W-1:0]      o_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          r_full;
    logic          r_empty;
    logic          w_wr;
    logic          w_rd;
    logic [AW:0]   w_count_nxt;

    // Full is registered, so a pop in the same cycle never admits a push
    assign w_wr = i_push & ~r_full;
    assign w_rd = i_pop & ~r_empty;
    assign w_count_nxt = r_count + (AW+1)'(w_wr) - (AW+1)'(w_rd);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_wr) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_rd) r_rptr <= r_rptr + 1'b1;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == LP_DEPTH);
            r_empty <= (w_count_nxt == '0);
        end
    end

    assign o_data  = r_mem[r_rptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;
    assign o_count = r_count;

endmodule

// File: rtl/mtpsa_digest_extract.sv
// mtpsa_digest_extract: forwards or drops packets by tuser drop bit, trims
// tuser to 128 bits, and queues per-packet digests toward the CPU.
// Ports: s_axis_* in, m_axis_* out (1-cycle registered), m_dig_* digest
// stream, pkt_drop_cnt/dig_drop_cnt saturating counters.
// Digest path built only when MTPSA_DIGEST_EN is defined.
module mtpsa_digest_extract
    import mtpsa_pkg::*;
#(
    parameter int C_AXIS_DATA_WIDTH    = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 304,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int DIGEST_WIDTH         = 256,
    parameter int DIGEST_FIFO_DEPTH    = 4
) (
    input  logic                              axis_aclk,
    input  logic                              axis_rst,
    input  logic [C_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]    s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast,
    output logic                              s_axis_tready,
    output logic [C_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]    m_axis_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready,
    output logic [DIGEST_WIDTH-1:0]           m_dig_tdata,
    output logic                              m_dig_tvalid,
    input  logic                              m_dig_tready,
    output logic [31:0]                       pkt_drop_cnt,
    output logic [31:0]                       dig_drop_cnt
);
    state_t                            r_state;
    logic [C_AXIS_DATA_WIDTH-1:0]      r_m_tdata;
    logic [C_AXIS_DATA_WIDTH/8-1:0]    r_m_tkeep;
    logic [C_M_AXIS_TUSER_WIDTH-1:0]   r_m_tuser;
    logic                              r_m_tvalid;
    logic                              r_m_tlast;
    logic [31:0]                       r_pkt_drop_cnt;

    logic                              w_s_ready;
    logic                              w_hs;
    logic                              w_sop;
    logic                              w_drop;
    logic                              w_load;
    logic [C_M_AXIS_TUSER_WIDTH-1:0]   w_meta;

    // Dropped beats never touch the output register, so DROP never stalls
    assign w_s_ready = axis_rst ? 1'b0 :
                       (r_state == ST_DROP) ? 1'b1 :
                       (~r_m_tvalid | m_axis_tready);
    assign w_hs   = s_axis_tvalid & w_s_ready;
    assign w_sop  = w_hs & (r_state == ST_IDLE);
    assign w_drop = s_axis_tuser[TU_DROP_BIT];
    assign w_load = w_hs & ((r_state == ST_PASS) |
                            ((r_state == ST_IDLE) & ~w_drop));

    always_comb begin
        w_meta = '0;
        w_meta[TU_META_W-1:0] = s_axis_tuser[TU_META_W-1:0];
    end

    always_ff @(posedge axis_aclk or posedge axis_rst) begin
        if (axis_rst) begin
            r_state    <= ST_IDLE;
            r_m_tdata  <= '0;
            r_m_tkeep  <= '0;
            r_m_tuser  <= '0;
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_sop && !s_axis_tlast)
                        r_state <= w_drop ? ST_DROP : ST_PASS;
                end
                ST_PASS, ST_DROP: begin
                    if (w_hs && s_axis_tlast) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
            if (w_load) begin
                r_m_tdata  <= s_axis_tdata;
                r_m_tkeep  <= s_axis_tkeep;
                r_m_tlast  <= s_axis_tlast;
                r_m_tvalid <= 1'b1;
                // metadata latched at SOP, held for the rest of the packet
                if (r_state == ST_IDLE) r_m_tuser <= w_meta;
            end else if (m_axis_tready) begin
                r_m_tvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge axis_aclk or posedge axis_rst) begin
        if (axis_rst)            r_pkt_drop_cnt <= '0;
        else if (w_sop && w_drop) r_pkt_drop_cnt <= sat_inc(r_pkt_drop_cnt);
    end

    assign s_axis_tready = w_s_ready;
    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tkeep  = r_m_tkeep;
    assign m_axis_tuser  = r_m_tuser;
    assign m_axis_tvalid = r_m_tvalid;
    assign m_axis_tlast  = r_m_tlast;
    assign pkt_drop_cnt  = r_pkt_drop_cnt;

`ifdef MTPSA_DIGEST_EN
    logic                               w_dig_push;
    logic                               w_dig_full;
    logic                               w_dig_empty;
    logic [$clog2(DIGEST_FIFO_DEPTH):0] w_dig_count;
    logic [31:0]                        r_dig_drop_cnt;
    logic                               w_unused_ok;

    // Digest is queued even when the packet itself is dropped
    assign w_dig_push = w_sop & s_axis_tuser[TU_SEND_DIG_BIT];

    mtpsa_digest_fifo #(
        .W     (DIGEST_WIDTH),
        .DEPTH (DIGEST_FIFO_DEPTH)
    ) u_fifo (
        .clk     (axis_aclk),
        .rst     (axis_rst),
        .i_push  (w_dig_push),
        .i_data  (s_axis_tuser[TU_DIGEST_LSB +: DIGEST_WIDTH]),
        .i_pop   (m_dig_tready),
        .o_data  (m_dig_tdata),
        .o_full  (w_dig_full),
        .o_empty (w_dig_empty),
        .o_count (w_dig_count)
    );

    assign m_dig_tvalid = ~w_dig_empty;

    always_ff @(posedge axis_aclk or posedge axis_rst) begin
        if (axis_rst)
            r_dig_drop_cnt <= '0;
        else if (w_dig_push && w_dig_full)
            r_dig_drop_cnt <= sat_inc(r_dig_drop_cnt);
    end

    assign dig_drop_cnt = r_dig_drop_cnt;
    assign w_unused_ok  = ^w_dig_count;
`else
    logic w_unused_ok;

    assign m_dig_tvalid = 1'b0;
    assign m_dig_tdata  = '0;
    assign dig_drop_cnt = '0;
    assign w_unused_ok  = ^{m_dig_tready,
                            s_axis_tuser[C_S_AXIS_TUSER_WIDTH-1:TU_META_W]};
`endif

endmodule
